// File: rtl/mux_rr_sequencer.sv
// Round-robin sequencer that time-shares an 8:1 mux between eight channels,
// holding each grant for a programmable dwell and capturing the mux output
// into a channel-tagged sample register at the end of the grant.
module mux_rr_sequencer #(
   parameter int unsigned N_CH    = 8,
   parameter int unsigned DWELL_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [N_CH-1:0]     req,
   input  logic [DWELL_W-1:0]  dwell,
   input  logic                mux_y,
   output logic [2:0]          sel,
   output logic [N_CH-1:0]     gnt,
   output logic                busy,
   output logic                sample_valid,
   output logic                sample_data,
   output logic [2:0]          sample_ch
);

   localparam int unsigned SEL_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t             state;
   logic [DWELL_W-1:0] cnt;
   logic [SEL_W-1:0]   last_ch;
   // Set on leaving HOLD: the following IDLE cycle is the return cycle and
   // does not arbitrate, giving a grant period of dwell + 2.
   logic               rearm;

   logic [SEL_W-1:0]   win;
   logic               win_found;
   logic [SEL_W-1:0]   cand;

   // Round-robin winner: first requesting channel after last_ch, wrapping 7->0.
   always_comb begin
      win       = '0;
      win_found = 1'b0;
      cand      = '0;
      for (int unsigned k = 1; k <= N_CH; k++) begin
         cand = last_ch + SEL_W'(k);
         if (!win_found && req[cand]) begin
            win       = cand;
            win_found = 1'b1;
         end
      end
   end

   // Grant/hold/sample state machine with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         last_ch      <= SEL_W'(N_CH - 1);
         rearm        <= 1'b0;
         sel          <= '0;
         gnt          <= '0;
         busy         <= 1'b0;
         sample_valid <= 1'b0;
         sample_data  <= 1'b0;
         sample_ch    <= '0;
      end else begin
         sample_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (rearm) begin
                  rearm <= 1'b0;
               end else if (en && win_found) begin
                  sel   <= win;
                  gnt   <= N_CH'(1) << win;
                  cnt   <= (dwell == '0) ? '0 : dwell - DWELL_W'(1);
                  busy  <= 1'b1;
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (!req[sel]) begin
                  // Requester withdrew: abort without a sample.
                  gnt     <= '0;
                  busy    <= 1'b0;
                  last_ch <= sel;
                  rearm   <= 1'b1;
                  state   <= IDLE;
               end else if (cnt == '0) begin
                  sample_data  <= mux_y;
                  sample_ch    <= sel;
                  sample_valid <= 1'b1;
                  gnt          <= '0;
                  busy         <= 1'b0;
                  last_ch      <= sel;
                  rearm        <= 1'b1;
                  state        <= IDLE;
               end else begin
                  cnt <= cnt - DWELL_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_rr_sequencer.sv
// Bench for mux_rr_sequencer: directed scenarios plus random traffic, every
// cycle compared against a transaction-level round-robin model.
module tb_mux_rr_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] req;
   logic [3:0] dwell;
   logic       mux_y;
   logic [2:0] sel;
   logic [7:0] gnt;
   logic       busy;
   logic       sample_valid;
   logic       sample_data;
   logic [2:0] sample_ch;

   logic [7:0] mux_data;

   int total = 0;
   int bad   = 0;
   int sv_count;

   // Reference model state: owner = granted channel or -1, left = grant
   // cycles still to go, gap = return cycle pending before next arbitration.
   int         m_owner;
   int         m_left;
   int         m_last;
   bit         m_gap;
   logic [2:0] m_sel;
   logic       m_sv;
   logic       m_sd;
   logic [2:0] m_sch;

   always #5 clk = ~clk;

   // The shared 8:1 mux the sequencer steers.
   assign mux_y = mux_data[sel];

   mux_rr_sequencer #(.N_CH(8), .DWELL_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .req          (req),
      .dwell        (dwell),
      .mux_y        (mux_y),
      .sel          (sel),
      .gnt          (gnt),
      .busy         (busy),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .sample_ch    (sample_ch)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   // Advance the model across one clock edge using the inputs present now.
   task automatic model_step();
      if (rst) begin
         m_owner = -1; m_left = 0; m_last = 7; m_gap = 1'b0;
         m_sel = 3'd0; m_sv = 1'b0; m_sd = 1'b0; m_sch = 3'd0;
      end else if (m_owner >= 0) begin
         m_sv = 1'b0;
         if (!req[m_owner]) begin
            m_last = m_owner; m_owner = -1; m_gap = 1'b1;
         end else if (m_left == 1) begin
            m_sv = 1'b1; m_sd = mux_data[m_owner]; m_sch = 3'(m_owner);
            m_last = m_owner; m_owner = -1; m_gap = 1'b1;
         end else begin
            m_left--;
         end
      end else begin
         m_sv = 1'b0;
         if (m_gap) begin
            m_gap = 1'b0;
         end else if (en && req != 8'h00) begin
            for (int k = 1; k <= 8; k++) begin
               if (m_owner < 0 && req[(m_last + k) % 8]) m_owner = (m_last + k) % 8;
            end
            m_sel  = 3'(m_owner);
            m_left = (dwell == 4'd0) ? 1 : int'(dwell);
         end
      end
   endtask

   task automatic compare_all();
      logic [7:0] eg;
      eg = 8'h00;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      check("gnt",          32'(gnt),          32'(eg));
      check("sel",          32'(sel),          32'(m_sel));
      check("busy",         32'(busy),         32'(m_owner >= 0));
      check("sample_valid", 32'(sample_valid), 32'(m_sv));
      check("sample_data",  32'(sample_data),  32'(m_sd));
      check("sample_ch",    32'(sample_ch),    32'(m_sch));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      if (sample_valid) sv_count++;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; req = 8'h00; dwell = 4'd1; mux_data = 8'h66;
      m_owner = -1; m_left = 0; m_last = 7; m_gap = 1'b0;
      m_sel = 3'd0; m_sv = 1'b0; m_sd = 1'b0; m_sch = 3'd0;

      // Reset with everything requesting; first grant goes to ch0.
      en = 1'b1; req = 8'hFF; dwell = 4'd2;
      do_reset(2);
      tick();
      check("first_gnt", 32'(gnt), 32'h01);

      // Full sweep: 8 samples in any 32-cycle window at dwell=2.
      mux_data = 8'b0110_0110;
      do_reset(1);
      sv_count = 0;
      repeat (32) tick();
      check("sweep_pulses", 32'(sv_count), 32'd8);
      repeat (8) tick();

      // Wrap and skip between ch0 and ch7.
      req = 8'h81; dwell = 4'd1;
      do_reset(1);
      repeat (16) tick();

      // Single requester on ch5.
      req = 8'h20; dwell = 4'd3;
      do_reset(1);
      sv_count = 0;
      repeat (20) tick();
      check("single_pulses", 32'(sv_count), 32'd4);

      // Abort: ch2 drops during its 2nd hold cycle, ch3 follows.
      req = 8'h0C; dwell = 4'd4;
      do_reset(1);
      tick();
      check("abort_first", 32'(gnt), 32'h04);
      tick();
      req = 8'h08;
      tick();
      check("abort_gnt", 32'(gnt), 32'h00);
      tick();
      tick();
      check("abort_next", 32'(gnt), 32'h08);
      repeat (6) tick();

      // dwell=0 behaves as dwell=1.
      req = 8'h01; dwell = 4'd0;
      do_reset(1);
      repeat (9) tick();

      // en dropped mid-HOLD: sample still arrives, nothing new granted.
      req = 8'h01; dwell = 4'd3;
      do_reset(1);
      tick();
      en = 1'b0;
      sv_count = 0;
      repeat (10) tick();
      check("en_off_pulses", 32'(sv_count), 32'd1);
      en = 1'b1;

      // Reset mid-HOLD: grant aborts, next grant restarts from ch0.
      req = 8'h24; dwell = 4'd5;
      do_reset(1);
      repeat (9) tick();
      check("pre_rst_gnt", 32'(gnt), 32'h20);
      do_reset(1);
      tick();
      check("post_rst_gnt", 32'(gnt), 32'h04);
      repeat (6) tick();

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         en  = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
         if ($urandom_range(0, 5) == 0) dwell = 4'($urandom_range(0, 6));
         if ($urandom_range(0, 15) == 0) mux_data = 8'($urandom);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux_rr_sequencer.md
Name: mux_rr_sequencer

Overview:
- Round-robin scheduler that shares the 8:1 multiplexer between eight requesting channels.
- Grants one channel at a time and drives the mux 3-bit select.
- Holds each grant for a programmable dwell time, then captures the mux output into a tagged sample register.
- Sits beside the 8:1 mux instance: its select output drives the mux select input, and the mux output returns on mux_y.

Parameters:
- N_CH, 8, number of channels. Fixed at 8; the select is 3 bits.
- DWELL_W, 4, width of the dwell input and the internal dwell counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbitration enable. Checked only in IDLE.
- req  input  8  per-channel request, level-sensitive.
- dwell  input  DWELL_W  cycles a grant is held. Sampled when the grant is issued. A value of 0 is treated as 1.
- mux_y  input  1  output of the 8:1 mux.
- sel  output  3  mux select. Registered, and stable for the whole grant.
- gnt  output  8  one-hot grant. All zeros when nothing is granted.
- busy  output  1  high while in HOLD.
- sample_valid  output  1  one-cycle pulse when a sample is captured.
- sample_data  output  1  captured mux_y value.
- sample_ch  output  3  channel that sample_data belongs to.

Behaviour:
- Reset: one clock cycle with rst=1 forces all outputs and internal state to their reset values.
  - sel=0, gnt=0, busy=0, sample_valid=0, sample_data=0, sample_ch=0.
  - State goes to IDLE, the dwell counter clears to 0, and last_ch=7 so channel 0 has first priority.
  - Reset asserted mid-grant aborts the grant immediately. No sample is produced.
- States: IDLE and HOLD.
- IDLE, when en=1 and |req:
  - Choose the winner w = first set req bit scanning last_ch+1, last_ch+2, ... modulo 8. The scan wraps 7 to 0.
  - Next edge: sel<=w, gnt<=1<<w, cnt<=max(dwell,1)-1, busy<=1, go to HOLD.
  - Round-robin is work-conserving. The winner is determined combinationally from req in the IDLE cycle.
- IDLE, when en=0 or req=0: stay in IDLE with all outputs at their idle values (gnt=0, busy=0).
- HOLD, when req[sel]=1 and cnt>0: cnt<=cnt-1.
- HOLD, when req[sel]=1 and cnt==0 (the last hold cycle):
  - Next edge: sample_data<=mux_y, sample_ch<=sel, sample_valid<=1 for exactly one cycle.
  - Also on that edge: last_ch<=sel, gnt<=0, busy<=0, go to IDLE.
  - sel keeps its value in IDLE. It changes only at the next grant.
- HOLD, when req[sel] drops to 0 (checked every cycle, including the last):
  - Abort on the next edge: gnt<=0, busy<=0, last_ch<=sel, go to IDLE.
  - No sample_valid. sample_data and sample_ch keep their previous values.
- en deasserted during HOLD does not abort. The current grant completes and sampling proceeds normally.
- Timing:
  - The grant is visible 1 cycle after the IDLE decision.
  - The mux output is sampled after D=max(dwell,1) grant cycles.
  - Back-to-back grants start every D+2 cycles: D hold cycles, one return-to-IDLE cycle, and the arbitration edge.
- Changes to dwell during HOLD have no effect until the next grant.
- Other req bits changing during HOLD have no effect until the next IDLE cycle.
- sample_valid is 0 in every cycle other than the single pulse.

Test Plan:
- Reset: assert rst for 2 cycles with req=8'hFF and en=1 -> sel=0, gnt=0, busy=0, sample_valid=0 throughout. The first grant after release is gnt=8'h01.
- Full sweep: mux data d=8'b01100110, req=8'hFF, en=1, dwell=2 -> gnt sequence 01,02,04,...,80,01.
  - Grants start every 4 cycles.
  - sample_ch runs 0..7.
  - sample_data runs 0,1,1,0,0,1,1,0 (bit sel of d).
  - Exactly 8 sample_valid pulses per sweep.
- Wrap and skip: req=8'h81, dwell=1 -> gnt alternates 01,80,01,80. The sample_data stream for d=8'h66 is 0,0,0,0.
- Single requester: req=8'h20, dwell=3 -> every grant is 8'h20 with sel=5. sample_data=1 for d=8'h66 on each pulse, 5 cycles apart.
- Abort: req=8'h0C, dwell=4, clear req[2] during the 2nd hold cycle.
  - Response: gnt drops on the next edge with no sample_valid.
  - Next grant is 8'h08 (ch3), and its sample completes normally.
- Boundaries: dwell=0 with req=8'h01 behaves exactly like dwell=1 (sample 1 cycle after grant).
  - en=0 raised mid-HOLD still yields the sample; no new grant follows while en=0.
  - rst pulsed mid-HOLD gives no sample, all outputs zero, and the next grant goes to the lowest requesting channel starting from ch0.
